i2s_to_pcm_framed: RTL and testbench
====================================

# i2s_to_pcm_framed

Frame-aware I2S to dual-mono PCM1704 converter; parametrised successor to the fixed delay-line converter. Tracks the I2S frame with a phase counter, captures the left and right words, and re-serialises both right-justified so the two PCM1704U chips latch simultaneously. Checks frame length, holds a lock status, and mutes to mid-scale (zero code) while unlocked or when MUTE is asserted. Sits between the I2S source pins and the two DAC chips in the CPLD.

## Interface
- SLOT_BITS, 32: BCK cycles per LRCK half-period; even, 16..64.
- OUT_BITS, 24: bits sent per channel; 16..SLOT_BITS-1.
- LOCK_FRAMES, 4: consecutive good frames before LOCKED asserts; 1..15.
- SWAP_LR, 0: 1 routes the I2S left word to the R outputs and the right word to the L outputs.
- BCK  in  1  bit clock and sole clock; all state is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- LRCK  in  1  I2S word clock; low = left slot.
- DATAIN  in  1  I2S data, MSB first, one-BCK delay after the LRCK edge.
- MUTE  in  1  synchronous; forces zero words at the next transfer.
- CLKOUTR, CLKOUTL  out  1  ~BCK, combinational.
- LEOUTR, LEOUTL  out  1  latch enable, registered, identical.
- DATAOUTR, DATAOUTL  out  1  serial data, registered, MSB first, two's complement.
- LOCKED  out  1  frame lock status.
- LED1  out  1  ~LOCKED; LED is on when locked.

## Operation
- LRCK is sampled into lrck_q. An edge is detected when LRCK != lrck_q. On an edge, bit_cnt <= 0; otherwise bit_cnt increments, saturating at 2*SLOT_BITS-1.
- Phase p = lrck_q*SLOT_BITS + bit_cnt. p=0 is the posedge detecting the falling LRCK edge. Frame length F = 2*SLOT_BITS.
- Capture uses the new bit_cnt value:
  - Left: bit_cnt 1..OUT_BITS in the left slot shift DATAIN into cap_l.
  - Right: the same bit_cnt range in the right slot shifts into cap_r.
  - Bits past OUT_BITS are discarded (truncation, no rounding).
- Slot check:
  - At every edge except the first after reset, the old bit_cnt must equal SLOT_BITS-1.
  - A mismatch clears good_cnt and LOCKED immediately.
  - At a good falling edge, good_cnt increments, saturating. LOCKED sets when good_cnt reaches LOCK_FRAMES.
- Transfer happens at p=0 (falling-edge detect).
  - out_l/out_r <= (LOCKED && !MUTE) ? cap_l/cap_r : 0, with SWAP_LR applied. LOCKED is the value before this edge.
  - Both channels always transfer together.
- Shift-out: for k = 0..OUT_BITS-1, the posedge at p = F-1-OUT_BITS+k drives bit OUT_BITS-1-k. DATAOUT is 0 at all other phases.
- LEOUT is registered 1 when p == F-1 or p < SLOT_BITS, and 0 otherwise.
  - Its rising edge follows the LSB by one BCK and latches the word.
  - Data is always driven while LE is low, which requires OUT_BITS <= SLOT_BITS-1.
- While unlocked, framing and LE continue and zero words are sent.
- If LRCK stops, bit_cnt saturates and outputs hold their final pattern (LE high, data 0). The next edge fails the check.

## Timing
- Reset values:
  - All registers 0: LEOUTx=0, DATAOUTx=0, LOCKED=0, LED1=1.
  - A first-edge flag suppresses the slot check on the first edge.
  - CLKOUTx follows ~BCK during reset.
- Data launches on BCK rise; the DAC samples on the CLKOUT rise (BCK fall), giving half a BCK of setup.
- Latency: the word of frame n transfers at p=0 of frame n+1 and is latched at the LE rise at p=F-1 of frame n+1, about 2F BCK after its MSB.
- Lock time: LOCK_FRAMES falling edges after the first correctly sized frame. Unlock takes 1 cycle from the bad edge. Zero output starts at the next transfer.
- Asserting RST mid-frame immediately clears outputs and lock. Relock requires a full LOCK_FRAMES sequence again.

## Test plan
- Reset with LRCK high, then 32-bit slots, L=0x123456, R=0xABCDEF (left-justified in the slot) → LOCKED rises at the 4th good falling edge. No spurious unlock from the first edge.
- Locked stream → in each frame, DATAOUTL serialises 0x123456 and DATAOUTR 0xABCDEF at p=39..62, and both LEs rise at p=63.
- One 31-BCK right slot while locked → LOCKED=0 on that edge. The next transfer sends 0x000000. Relock after 4 good frames.
- MUTE=1 for one frame while locked → exactly one frame of zero words. LOCKED stays 1.
- SWAP_LR=1 with the same data → DATAOUTL carries 0xABCDEF and DATAOUTR 0x123456. OUT_BITS=16, SLOT_BITS=32 → 0x1234 and 0xABCD at p=47..62.
- RST pulse mid-shift → DATAOUTx=0, LEOUTx=0, and LED1=1 within the reset; sequencing restarts cleanly.

Source files
------------

// File: rtl/i2s_to_pcm_framed.sv
// i2s_to_pcm_framed
// Frame-aware I2S receiver that re-serialises the left and right words for two
// PCM1704U DACs. The two DACs share one latch-enable timing, so both words are
// latched together. Words are right-justified against the LE rising edge. A frame
// length check drives a lock status. While unlocked or muted, the DACs get
// zero (mid-scale) words.
//
// Ports
//   BCK                 bit clock, sole clock (rising edge)
//   RST                 asynchronous active-high reset
//   LRCK                I2S word clock, low = left slot
//   DATAIN              I2S serial data, MSB first, one BCK after LRCK edge
//   MUTE                synchronous mute, sampled at the word transfer
//   CLKOUTR/CLKOUTL     ~BCK to the DACs
//   LEOUTR/LEOUTL       latch enable (registered, identical)
//   DATAOUTR/DATAOUTL   serial data to the DACs, MSB first, two's complement
//   LOCKED              frame lock status
//   LED1                ~LOCKED (active-low LED)
module i2s_to_pcm_framed #(
    parameter int unsigned SLOT_BITS   = 32,
    parameter int unsigned OUT_BITS    = 24,
    parameter int unsigned LOCK_FRAMES = 4,
    parameter bit          SWAP_LR     = 1'b0
) (
    input  logic BCK,
    input  logic RST,
    input  logic LRCK,
    input  logic DATAIN,
    input  logic MUTE,
    output logic CLKOUTR,
    output logic CLKOUTL,
    output logic LEOUTR,
    output logic LEOUTL,
    output logic DATAOUTR,
    output logic DATAOUTL,
    output logic LOCKED,
    output logic LED1
);

    localparam int unsigned FRAME = 2 * SLOT_BITS;
    localparam int unsigned CW    = $clog2(FRAME);
    localparam int unsigned PW    = CW + 1;
    localparam int unsigned IW    = $clog2(OUT_BITS);

    localparam logic [CW-1:0] CNT_MAX   = CW'(FRAME - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_BITS - 1);
    localparam logic [CW-1:0] CAP_LAST  = CW'(OUT_BITS);
    localparam logic [PW-1:0] P_LAST    = PW'(FRAME - 1);
    localparam logic [PW-1:0] P_SH_LAST = PW'(FRAME - 2);
    localparam logic [PW-1:0] P_SH_FRST = PW'(FRAME - 1 - OUT_BITS);
    localparam logic [PW-1:0] P_SLOT    = PW'(SLOT_BITS);
    localparam logic [3:0]    LOCK_TGT  = 4'(LOCK_FRAMES);

    typedef enum logic {
        LK_HUNT   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_e;

    logic                lrck_q;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic                seen_q,  seen_d;
    logic [3:0]          good_q,  good_d;
    lock_e               lock_q,  lock_d;
    logic [OUT_BITS-1:0] cap_l_q, cap_l_d;
    logic [OUT_BITS-1:0] cap_r_q, cap_r_d;
    logic [OUT_BITS-1:0] out_l_q, out_l_d;
    logic [OUT_BITS-1:0] out_r_q, out_r_d;
    logic                le_q,    le_d;
    logic                dl_q,    dl_d;
    logic                dr_q,    dr_d;

    logic          edge_det;
    logic          fall;
    logic          cap_en;
    logic          pass;
    logic          in_win;
    logic [PW-1:0] phase_raw;
    logic [PW-1:0] phase;
    logic [IW-1:0] idx;

    always_comb begin
        edge_det = LRCK ^ lrck_q;
        fall     = edge_det & ~LRCK;

        if (edge_det)
            cnt_d = '0;
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;

        // Phase of this edge from the new LRCK/count. A stalled LRCK-high slot
        // would run past the frame end; clamping holds the end-of-frame pattern.
        phase_raw = (LRCK ? P_SLOT : '0) + PW'(cnt_d);
        phase     = (phase_raw > P_LAST) ? P_LAST : phase_raw;

        seen_d = seen_q | edge_det;
        good_d = good_q;
        lock_d = lock_q;
        if (edge_det && seen_q && (cnt_q != SLOT_LAST)) begin
            good_d = '0;
            lock_d = LK_HUNT;
        end else if (fall && seen_q) begin
            if (good_q != 4'hF)
                good_d = good_q + 4'd1;
            if (good_d >= LOCK_TGT)
                lock_d = LK_LOCKED;
        end

        cap_en  = (cnt_d != '0) && (cnt_d <= CAP_LAST);
        cap_l_d = cap_l_q;
        cap_r_d = cap_r_q;
        if (cap_en && !LRCK)
            cap_l_d = {cap_l_q[OUT_BITS-2:0], DATAIN};
        if (cap_en && LRCK)
            cap_r_d = {cap_r_q[OUT_BITS-2:0], DATAIN};

        // Lock status before this edge decides whether the finished frame goes out.
        pass    = (lock_q == LK_LOCKED) && !MUTE;
        out_l_d = out_l_q;
        out_r_d = out_r_q;
        if (fall) begin
            out_l_d = pass ? (SWAP_LR ? cap_r_q : cap_l_q) : '0;
            out_r_d = pass ? (SWAP_LR ? cap_l_q : cap_r_q) : '0;
        end

        le_d = (phase == P_LAST) || (phase < P_SLOT);

        // The word ends one BCK before the LE rise: bit (F-2-p) at phase p.
        in_win = (phase >= P_SH_FRST) && (phase <= P_SH_LAST);
        idx    = IW'(P_SH_LAST - phase);
        dl_d   = in_win ? out_l_q[idx] : 1'b0;
        dr_d   = in_win ? out_r_q[idx] : 1'b0;
    end

    always_ff @(posedge BCK or posedge RST) begin
        if (RST) begin
            lrck_q  <= 1'b0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            good_q  <= '0;
            lock_q  <= LK_HUNT;
            cap_l_q <= '0;
            cap_r_q <= '0;
            out_l_q <= '0;
            out_r_q <= '0;
            le_q    <= 1'b0;
            dl_q    <= 1'b0;
            dr_q    <= 1'b0;
        end else begin
            lrck_q  <= LRCK;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            good_q  <= good_d;
            lock_q  <= lock_d;
            cap_l_q <= cap_l_d;
            cap_r_q <= cap_r_d;
            out_l_q <= out_l_d;
            out_r_q <= out_r_d;
            le_q    <= le_d;
            dl_q    <= dl_d;
            dr_q    <= dr_d;
        end
    end

    assign CLKOUTR  = ~BCK;
    assign CLKOUTL  = ~BCK;
    assign LEOUTR   = le_q;
    assign LEOUTL   = le_q;
    assign DATAOUTR = dr_q;
    assign DATAOUTL = dl_q;
    assign LOCKED   = (lock_q == LK_LOCKED);
    assign LED1     = ~LOCKED;

endmodule

// File: tb/tb_i2s_to_pcm_framed.sv
// Testbench for i2s_to_pcm_framed: three instances (default, SWAP_LR=1,
// OUT_BITS=16) share one I2S stream driven frame by frame from a vector table.
module tb_i2s_to_pcm_framed;

    logic BCK = 1'b0;
    logic RST, LRCK, DATAIN, MUTE;

    logic a_clkr, a_clkl, a_ler, a_lel, a_dr, a_dl, a_lk, a_led;
    logic s_clkr, s_clkl, s_ler, s_lel, s_dr, s_dl, s_lk, s_led;
    logic h_clkr, h_clkl, h_ler, h_lel, h_dr, h_dl, h_lk, h_led;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 BCK = ~BCK;

    i2s_to_pcm_framed #(.SLOT_BITS(32), .OUT_BITS(24), .LOCK_FRAMES(4), .SWAP_LR(1'b0)) u_a (
        .BCK(BCK), .RST(RST), .LRCK(LRCK), .DATAIN(DATAIN), .MUTE(MUTE),
        .CLKOUTR(a_clkr), .CLKOUTL(a_clkl), .LEOUTR(a_ler), .LEOUTL(a_lel),
        .DATAOUTR(a_dr), .DATAOUTL(a_dl), .LOCKED(a_lk), .LED1(a_led));

    i2s_to_pcm_framed #(.SLOT_BITS(32), .OUT_BITS(24), .LOCK_FRAMES(4), .SWAP_LR(1'b1)) u_s (
        .BCK(BCK), .RST(RST), .LRCK(LRCK), .DATAIN(DATAIN), .MUTE(MUTE),
        .CLKOUTR(s_clkr), .CLKOUTL(s_clkl), .LEOUTR(s_ler), .LEOUTL(s_lel),
        .DATAOUTR(s_dr), .DATAOUTL(s_dl), .LOCKED(s_lk), .LED1(s_led));

    i2s_to_pcm_framed #(.SLOT_BITS(32), .OUT_BITS(16), .LOCK_FRAMES(4), .SWAP_LR(1'b0)) u_h (
        .BCK(BCK), .RST(RST), .LRCK(LRCK), .DATAIN(DATAIN), .MUTE(MUTE),
        .CLKOUTR(h_clkr), .CLKOUTL(h_clkl), .LEOUTR(h_ler), .LEOUTL(h_lel),
        .DATAOUTR(h_dr), .DATAOUTL(h_dl), .LOCKED(h_lk), .LED1(h_led));

    typedef struct packed {
        logic [23:0] l;      // left word, left-justified in the 32-bit slot
        logic [23:0] r;
        logic [5:0]  rlen;   // right slot length in BCK
        logic        mute;
        logic        lock;   // LOCKED expected just after this frame's falling edge
        logic [23:0] el;     // words expected on the unswapped outputs this frame
        logic [23:0] er;
    } frame_t;

    frame_t vec [16];

    function automatic frame_t mk(input logic [23:0] l, input logic [23:0] r,
                                  input logic [5:0] rlen, input logic mute,
                                  input logic lock, input logic [23:0] el,
                                  input logic [23:0] er);
        frame_t f;
        f.l = l; f.r = r; f.rlen = rlen; f.mute = mute;
        f.lock = lock; f.el = el; f.er = er;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // I2S bit for cycle i of a frame: MSB one BCK after the slot starts.
    function automatic logic sbit(input logic [23:0] l, input logic [23:0] r, input int unsigned i);
        logic [31:0] w;
        int unsigned j;
        logic [4:0]  bi;
        w = (i >= 32) ? {r, 8'h00} : {l, 8'h00};
        j = (i >= 32) ? i - 32 : i;
        if (j == 0) return 1'b0;
        bi = 5'(32 - j);
        return w[bi];
    endfunction

    task automatic tick(input logic lr, input logic d);
        @(negedge BCK);
        LRCK   = lr;
        DATAIN = d;
        @(posedge BCK);
        #1;
    endtask

    task automatic preamble(input logic [23:0] r);
        for (int unsigned i = 0; i < 32; i++)
            tick(1'b1, sbit(24'h0, r, 32 + i));
    endtask

    task automatic run_frame(input frame_t f, input string tag);
        logic [23:0] ga_l, ga_r, gs_l, gs_r;
        logic [15:0] gh_l, gh_r;
        logic        stray, le_bad, exp_le;
        int unsigned len;
        ga_l = '0; ga_r = '0; gs_l = '0; gs_r = '0; gh_l = '0; gh_r = '0;
        stray = 1'b0; le_bad = 1'b0;
        len = 32 + int'(f.rlen);
        MUTE = f.mute;
        for (int unsigned i = 0; i < len; i++) begin
            tick(i >= 32, sbit(f.l, f.r, i));
            if (i == 0) begin
                check({tag, " locked"},      {29'd0, a_lk, s_lk, h_lk}, {29'd0, {3{f.lock}}});
                check({tag, " led"},         {31'd0, a_led}, {31'd0, ~f.lock});
            end
            exp_le = (i < 32) || (i == 63);
            if ({a_ler, a_lel, s_ler, s_lel, h_ler, h_lel} !== {6{exp_le}})
                le_bad = 1'b1;
            if (i >= 39 && i <= 62) begin
                ga_l = {ga_l[22:0], a_dl}; ga_r = {ga_r[22:0], a_dr};
                gs_l = {gs_l[22:0], s_dl}; gs_r = {gs_r[22:0], s_dr};
            end else begin
                stray = stray | a_dl | a_dr | s_dl | s_dr;
            end
            if (i >= 47 && i <= 62) begin
                gh_l = {gh_l[14:0], h_dl}; gh_r = {gh_r[14:0], h_dr};
            end else begin
                stray = stray | h_dl | h_dr;
            end
        end
        check({tag, " dataL"},      {8'd0, ga_l}, {8'd0, f.el});
        check({tag, " dataR"},      {8'd0, ga_r}, {8'd0, f.er});
        check({tag, " swap dataL"}, {8'd0, gs_l}, {8'd0, f.er});
        check({tag, " swap dataR"}, {8'd0, gs_r}, {8'd0, f.el});
        check({tag, " 16b dataL"},  {16'd0, gh_l}, {16'd0, f.el[23:8]});
        check({tag, " 16b dataR"},  {16'd0, gh_r}, {16'd0, f.er[23:8]});
        check({tag, " data idle"},  {31'd0, stray}, 32'd0);
        check({tag, " le"},         {31'd0, le_bad}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b0, 24'h000000, 24'h000000);
        vec[1]  = mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b0, 24'h000000, 24'h000000);
        vec[2]  = mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b0, 24'h000000, 24'h000000);
        vec[3]  = mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b1, 24'h000000, 24'h000000);
        vec[4]  = mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b1, 24'h123456, 24'hABCDEF);
        vec[5]  = mk(24'h5A5A5A, 24'h0F0F0F, 6'd32, 1'b0, 1'b1, 24'h123456, 24'hABCDEF);
        vec[6]  = mk(24'h123456, 24'hABCDEF, 6'd31, 1'b0, 1'b1, 24'h5A5A5A, 24'h0F0F0F);
        vec[7]  = mk(24'hC3C3C3, 24'h3C3C3C, 6'd32, 1'b0, 1'b0, 24'h123456, 24'hABCDEF);
        vec[8]  = mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b0, 24'h000000, 24'h000000);
        vec[9]  = mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b0, 24'h000000, 24'h000000);
        vec[10] = mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b0, 24'h000000, 24'h000000);
        vec[11] = mk(24'h800001, 24'hFFFFFF, 6'd32, 1'b0, 1'b1, 24'h000000, 24'h000000);
        vec[12] = mk(24'h13579B, 24'h2468AC, 6'd32, 1'b0, 1'b1, 24'h800001, 24'hFFFFFF);
        vec[13] = mk(24'h777777, 24'h888888, 6'd32, 1'b1, 1'b1, 24'h000000, 24'h000000);
        vec[14] = mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b1, 24'h777777, 24'h888888);
        vec[15] = mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b1, 24'h123456, 24'hABCDEF);

        RST = 1'b1; LRCK = 1'b1; DATAIN = 1'b0; MUTE = 1'b0;
        repeat (3) tick(1'b1, 1'b0);
        check("reset le",     {30'd0, a_lel, a_ler}, 32'd0);
        check("reset data",   {30'd0, a_dl, a_dr}, 32'd0);
        check("reset locked", {31'd0, a_lk}, 32'd0);
        check("reset led",    {31'd0, a_led}, 32'd1);
        check("reset clkout", {30'd0, a_clkl, a_clkr}, 32'd0);
        @(negedge BCK); #1;
        check("reset clkout low", {30'd0, a_clkl, a_clkr}, 32'd3);
        @(posedge BCK); #1;

        RST = 1'b0;
        preamble(24'hABCDEF);
        for (int unsigned n = 0; n < 16; n++)
            run_frame(vec[n], $sformatf("frame%0d", n + 1));

        // Reset in the middle of the shift-out window of a locked frame.
        MUTE = 1'b0;
        for (int unsigned i = 0; i < 46; i++)
            tick(i >= 32, sbit(24'h123456, 24'hABCDEF, i));
        RST = 1'b1;
        #1;
        check("midrst le",     {26'd0, a_lel, a_ler, s_lel, s_ler, h_lel, h_ler}, 32'd0);
        check("midrst data",   {26'd0, a_dl, a_dr, s_dl, s_dr, h_dl, h_dr}, 32'd0);
        check("midrst locked", {29'd0, a_lk, s_lk, h_lk}, 32'd0);
        check("midrst led",    {29'd0, a_led, s_led, h_led}, 32'd7);
        repeat (2) tick(1'b1, 1'b0);
        check("midrst hold locked", {31'd0, a_lk}, 32'd0);
        check("midrst clkout",      {30'd0, a_clkl, a_clkr}, 32'd0);
        RST = 1'b0;

        preamble(24'h000000);
        run_frame(mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b0, 24'h0, 24'h0), "relock1");
        run_frame(mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b0, 24'h0, 24'h0), "relock2");
        run_frame(mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b0, 24'h0, 24'h0), "relock3");
        run_frame(mk(24'h2468AC, 24'h13579B, 6'd32, 1'b0, 1'b1, 24'h0, 24'h0), "relock4");
        run_frame(mk(24'h123456, 24'hABCDEF, 6'd32, 1'b0, 1'b1, 24'h2468AC, 24'h13579B), "relock5");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
